// File: rtl/uart_rx_frame_ctrl.sv
// ============================================================================
// uart_rx_frame_ctrl : sync hunt, frame parse and checksum-gated write burst
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop,
  output logic       busy
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [1:0] c_ERR_LEN = 2'd1;
  localparam logic [1:0] c_ERR_CHK = 2'd2;
  localparam logic [1:0] c_ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CHK   = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_valid_q, wr_valid_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          rx_drop_q, rx_drop_d;
  logic          busy_q, busy_d;

  logic [7:0]    pbuf_q [MAX_LEN];
  logic          w_buf_we;
  logic [IW-1:0] w_idx_inc;
  logic          w_timed;
  logic          w_timeout;

  assign w_idx_inc = idx_q + IW'(1);
  assign w_timed   = (state_q == S_ADDR) || (state_q == S_LEN) ||
                     (state_q == S_DATA) || (state_q == S_CHK);
  // A byte on the expiry cycle takes priority over the abort.
  assign w_timeout = w_timed && !rx_valid && (tmo_q == TW'(TIMEOUT_CLKS - 1));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    tmo_d        = (rx_valid || !w_timed) ? '0 : tmo_q + TW'(1);
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    rx_drop_d    = 1'b0;
    w_buf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rx_valid) begin
          base_d  = rx_data;
          chk_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
            frame_err_d = 1'b1;
            err_code_d  = c_ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            chk_d   = chk_q ^ rx_data;
            len_d   = rx_data[IW-1:0];
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          w_buf_we = 1'b1;
          chk_d    = chk_q ^ rx_data;
          idx_d    = w_idx_inc;
          if (w_idx_inc == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = base_q;
            wr_data_d  = pbuf_q[0];
            idx_d      = '0;
            state_d    = S_WRITE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = c_ERR_CHK;
            state_d     = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        rx_drop_d = rx_valid;
        if (wr_valid_q && wr_ready) begin
          if (w_idx_inc == len_q) begin
            wr_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            idx_d     = w_idx_inc;
            wr_addr_d = base_q + 8'(w_idx_inc);
            wr_data_d = pbuf_q[w_idx_inc[AW-1:0]];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_timeout) begin
      frame_err_d = 1'b1;
      err_code_d  = c_ERR_TMO;
      state_d     = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      rx_drop_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      tmo_q        <= tmo_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      rx_drop_q    <= rx_drop_d;
      busy_q       <= busy_d;
    end
  end

  // Payload storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (w_buf_we) pbuf_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign rx_drop    = rx_drop_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire
